// File: rtl/bep_pkg.sv
// Shared definitions for the BEP thermostat serial link.
// Holds the header constants, frame geometry, payload field offsets and the payload
// layout. serial_encode and the receive-side checker both import this package, so
// the two ends of the link always agree on what a frame looks like.
package bep_pkg;

  // Frame geometry
  localparam int unsigned HEADER_BITS  = 96;
  localparam int unsigned PAYLOAD_BITS = 96;
  localparam int unsigned FRAME_BITS   = HEADER_BITS + PAYLOAD_BITS;

  // Header words, transmitted in this order
  localparam logic [31:0] PREAMBLE = 32'h5555_5555;
  localparam logic [15:0] TYPE_1   = 16'h0F0F;
  localparam logic [15:0] TYPE_2   = 16'hF0F0;
  localparam logic [31:0] CONSTANT = 32'hDEAD_BEEF;

  localparam logic [HEADER_BITS-1:0] HEADER = {PREAMBLE, TYPE_1, TYPE_2, CONSTANT};

  // Least-significant bit of each field within the 96-bit payload
  localparam int unsigned THERMOSTAT_ID_LSB = 64;
  localparam int unsigned ROOM_TEMP_LSB     = 48;
  localparam int unsigned SET_TEMP_LSB      = 32;
  localparam int unsigned STATE_LSB         = 24;
  localparam int unsigned TAIL_1_LSB        = 16;
  localparam int unsigned TAIL_2_LSB        = 8;
  localparam int unsigned TAIL_3_LSB        = 0;

  // Index of the first bit on the line; bit_cnt starts here for each copy
  localparam logic [7:0] LAST_BIT_IDX = 8'(FRAME_BITS - 1);

  // Payload layout; member order matches the offsets above (MSB first)
  typedef struct packed {
    logic [31:0] thermostat_id;
    logic [15:0] room_temp;
    logic [15:0] set_temp;
    logic [7:0]  state;
    logic [7:0]  tail_1;
    logic [7:0]  tail_2;
    logic [7:0]  tail_3;
  } payload_t;

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StGap
  } enc_state_e;

  // Full frame image as it is loaded into the shifter: header first, then payload
  function automatic logic [FRAME_BITS-1:0] build_frame(input payload_t payload);
    return {HEADER, payload};
  endfunction

endpackage

// File: rtl/frame_shifter.sv
// frame_shifter: 192-bit parallel-load shift register, MSB out first.
// Ports:
//   serial_clock  in   clock
//   reset_n       in   asynchronous active-low reset, clears the register
//   load          in   load load_data (has priority over shift)
//   shift         in   shift left by one, filling with zero
//   load_data     in   frame image to load
//   msb           out  current most-significant bit (the bit on the line)
module frame_shifter
  import bep_pkg::*;
(
  input  logic                  serial_clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] load_data,
  output logic                  msb
);

  logic [FRAME_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[FRAME_BITS-1];

endmodule

// File: rtl/serial_encode.sv
// serial_encode: transmit side of the BEP thermostat serial link.
// On an accepted start the 96-bit payload is latched and REPEATS copies of the
// 192-bit frame {header, payload} are sent MSB first, one bit per clock, with
// GAP_BITS idle zeros between copies. done pulses once after the final bit.
// Ports:
//   serial_clock   in   sole clock
//   reset_n        in   asynchronous active-low reset
//   start          in   transfer request, accepted only while ready=1
//   thermostat_id  in   payload bits 95:64
//   room_temp      in   payload bits 63:48
//   set_temp       in   payload bits 47:32
//   state          in   payload bits 31:24
//   tail_1         in   payload bits 23:16 (CRC byte, passed through)
//   tail_2         in   payload bits 15:8
//   tail_3         in   payload bits 7:0
//   ready          out  high while idle
//   serial_data    out  line bit, zero when idle and in gaps
//   frame_active   out  high while serial_data carries a frame bit
//   done           out  one-cycle pulse after the last bit of the last copy
module serial_encode
  import bep_pkg::*;
#(
  parameter int unsigned REPEATS  = 3,   // 1..15
  parameter int unsigned GAP_BITS = 16   // 1..255
) (
  input  logic        serial_clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  output logic        ready,
  output logic        serial_data,
  output logic        frame_active,
  output logic        done
);

  localparam logic [3:0] REP_INIT = 4'(REPEATS - 1);
  localparam logic [7:0] GAP_INIT = 8'(GAP_BITS - 1);

  enc_state_e state_q, state_d;

  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] rep_cnt_q, rep_cnt_d;
  logic       done_q, done_d;
  payload_t   payload_q, payload_d;

  payload_t              in_payload;
  payload_t              load_payload;
  logic [FRAME_BITS-1:0] load_frame;
  logic                  sr_load;
  logic                  sr_shift;
  logic                  sr_msb;

  assign in_payload = '{
    thermostat_id: thermostat_id,
    room_temp:     room_temp,
    set_temp:      set_temp,
    state:         state,
    tail_1:        tail_1,
    tail_2:        tail_2,
    tail_3:        tail_3
  };

  // A fresh transfer loads straight from the inputs; later copies reuse the latch
  assign load_payload = (state_q == StIdle) ? in_payload : payload_q;
  assign load_frame   = build_frame(load_payload);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFrame;
        end
      end
      StFrame: begin
        if (bit_cnt_q == 8'd0) begin
          state_d = (rep_cnt_q != 4'd0) ? StGap : StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = StFrame;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rep_cnt_d = rep_cnt_q;
    payload_d = payload_q;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          payload_d = in_payload;
          sr_load   = 1'b1;
          bit_cnt_d = LAST_BIT_IDX;
          rep_cnt_d = REP_INIT;
        end
      end
      StFrame: begin
        if (bit_cnt_q != 8'd0) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - 8'd1;
        end else if (rep_cnt_q != 4'd0) begin
          gap_cnt_d = GAP_INIT;
          rep_cnt_d = rep_cnt_q - 4'd1;
        end else begin
          done_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q != 8'd0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else begin
          sr_load   = 1'b1;
          bit_cnt_d = LAST_BIT_IDX;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
      payload_q <= '0;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      payload_q <= payload_d;
      done_q    <= done_d;
    end
  end

  frame_shifter u_frame_shifter (
    .serial_clock (serial_clock),
    .reset_n      (reset_n),
    .load         (sr_load),
    .shift        (sr_shift),
    .load_data    (load_frame),
    .msb          (sr_msb)
  );

  // All outputs are decoded directly from flops; the shifter's stale contents are
  // masked outside FRAME so the line is zero when idle and in gaps.
  assign ready        = (state_q == StIdle);
  assign frame_active = (state_q == StFrame);
  assign serial_data  = frame_active & sr_msb;
  assign done         = done_q;

endmodule
